// File: rtl/campaign_pkg.sv
// Shared types and PRNG helpers for the fault-injection campaign controller.
// Two-tap Fibonacci LFSR taps are tabulated per width so other benchmarks can reuse the PRNG.
package campaign_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int LFSR_MAX_W = 64;

    typedef logic [5:0] tap_t;

    // The high tap is always the MSB for a Fibonacci x^w + x^k + 1 polynomial.
    function automatic tap_t lfsr_tap_hi(input int w);
        return tap_t'(w - 1);
    endfunction

    function automatic tap_t lfsr_tap_lo(input int w);
        case (w)
            36:      return tap_t'(24);
            33:      return tap_t'(19);
            31:      return tap_t'(27);
            28:      return tap_t'(24);
            25:      return tap_t'(21);
            23:      return tap_t'(17);
            20:      return tap_t'(16);
            17:      return tap_t'(13);
            15:      return tap_t'(13);
            default: return tap_t'(w - 2);
        endcase
    endfunction

    // Bits above the caller's width are don't-care; the caller truncates the result.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] cur,
        input tap_t                  hi,
        input tap_t                  lo
    );
        return {cur[LFSR_MAX_W-2:0], cur[hi] ^ cur[lo]};
    endfunction

endpackage

// File: rtl/campaign_lfsr.sv
// Loadable Fibonacci LFSR used as the vector source of a fault campaign.
// A zero seed is replaced by 1 so the register can never lock up in the all-zero state.
module campaign_lfsr
    import campaign_pkg::*;
#(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] seed,
    output logic [W-1:0] state
);

    localparam tap_t TAP_HI = lfsr_tap_hi(W);
    localparam tap_t TAP_LO = lfsr_tap_lo(W);

    logic [W-1:0] next_state;

    assign next_state = W'(lfsr_next(LFSR_MAX_W'(state), TAP_HI, TAP_LO));

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= '0;
        end else if (load) begin
            state <= (seed == '0) ? W'(1) : seed;
        end else if (enable) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Streams LFSR vectors into a faulty and a golden benchmark wrapper in lock-step and
// compares their outputs LAT edges later, accumulating mismatch statistics for the host.
module fault_campaign_ctrl
    import campaign_pkg::*;
#(
    parameter int IN_W  = 36,
    parameter int OUT_W = 7,
    parameter int LAT   = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [IN_W-1:0]  seed,
    output logic [IN_W-1:0]  dut_in,
    output logic             inj_en,
    input  logic [OUT_W-1:0] dut_out,
    input  logic [OUT_W-1:0] gold_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [OUT_W-1:0] err_bits
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           st;
    logic [LAT-1:0]   vpipe;
    logic [LAT-1:0]   vpipe_next;
    logic [CNT_W-1:0] remaining;
    logic             accept_start;
    logic             issue;
    logic             compare;
    logic [OUT_W-1:0] mism;

    // NOTE: every signal written here gets a value on every path first, so no latch
    // can be inferred even if a later branch is edited.
    always_comb begin
        accept_start = 1'b0;
        issue        = 1'b0;
        if ((st == IDLE) || (st == DONE)) begin
            accept_start = start;
        end
        if (st == RUN) begin
            issue = !abort;
        end
        vpipe_next = LAT'({vpipe, issue});
        compare    = vpipe[LAT-1];
        mism       = dut_out ^ gold_out;
    end

    campaign_lfsr #(
        .W(IN_W)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept_start),
        .enable (issue),
        .seed   (seed),
        .state  (dut_in)
    );

    // Valid pipe and result counters; a vector is scored the edge after its valid bit exits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vpipe     <= '0;
            vec_count <= '0;
            err_count <= '0;
            err_bits  <= '0;
        end else begin
            vpipe <= vpipe_next;
            if (accept_start) begin
                vec_count <= '0;
                err_count <= '0;
                err_bits  <= '0;
            end else if (compare) begin
                vec_count <= vec_count + ONE;
                err_bits  <= err_bits | mism;
                if ((|mism) && (err_count != '1)) begin
                    err_count <= err_count + ONE;
                end
            end
        end
    end

    // Campaign FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            inj_en    <= 1'b0;
        end else begin
            unique case (st)
                IDLE, DONE: begin
                    if (start) begin
                        remaining <= num_vectors;
                        done      <= 1'b0;
                        if (num_vectors == '0) begin
                            st     <= DONE;
                            busy   <= 1'b0;
                            inj_en <= 1'b0;
                        end else begin
                            st     <= RUN;
                            busy   <= 1'b1;
                            inj_en <= 1'b1;
                        end
                    end else if (st == DONE) begin
                        done <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        remaining <= remaining - ONE;
                    end
                    if (abort || (remaining == ONE)) begin
                        st <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (vpipe == '0) begin
                        st     <= DONE;
                        busy   <= 1'b0;
                        inj_en <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    st     <= IDLE;
                    busy   <= 1'b0;
                    inj_en <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl: a vector table of whole campaigns plus
// hand-written sequences for reset, LFSR stepping, abort, busy-start and saturation.
module tb_fault_campaign_ctrl;

    localparam int IN_W  = 36;
    localparam int OUT_W = 7;
    localparam int LAT   = 2;
    localparam int CNT_W = 32;
    localparam int NCASE = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_vectors;
    logic [IN_W-1:0]  seed;
    logic [IN_W-1:0]  dut_in;
    logic             inj_en;
    logic [OUT_W-1:0] dut_out;
    logic [OUT_W-1:0] gold_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] err_count;
    logic [OUT_W-1:0] err_bits;

    int               errors = 0;
    int               checks = 0;

    // Wrapper model: two register stages, faulty copy = golden ^ injected mask.
    int               fault_mode = 0;
    logic [IN_W-1:0]  bad_vec = '0;
    logic [IN_W-1:0]  w_s1 = '0;
    logic [IN_W-1:0]  w_s2 = '0;
    logic [OUT_W-1:0] fmask;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_s1 <= dut_in;
        w_s2 <= w_s1;
    end

    assign gold_out = w_s2[6:0] ^ w_s2[35:29];

    always_comb begin
        fmask = '0;
        if (fault_mode == 1 && w_s2 == bad_vec) fmask = 7'h01;
        else if (fault_mode == 2)               fmask = 7'h55;
    end

    assign dut_out = gold_out ^ fmask;

    fault_campaign_ctrl #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .LAT   (LAT),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .num_vectors (num_vectors),
        .seed        (seed),
        .dut_in      (dut_in),
        .inj_en      (inj_en),
        .dut_out     (dut_out),
        .gold_out    (gold_out),
        .busy        (busy),
        .done        (done),
        .vec_count   (vec_count),
        .err_count   (err_count),
        .err_bits    (err_bits)
    );

    typedef struct {
        logic [CNT_W-1:0] n;
        logic [IN_W-1:0]  seed;
        int               mode;
        logic [IN_W-1:0]  bad;
        logic             abort_in;
        int               exp_vec;
        int               exp_err;
        logic [OUT_W-1:0] exp_bits;
        int               exp_edges;
        logic             exp_inj;
    } vec_t;

    vec_t tbl [NCASE];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 300) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        int  edges;
        logic inj_seen;

        //            n       seed            mode bad             abt vec err bits   edges inj
        tbl[0] = '{32'd3, 36'd1,            0, 36'd0,            1'b1, 3, 0, 7'h00, 6, 1'b1};
        tbl[1] = '{32'd4, 36'd1,            1, 36'd2,            1'b0, 4, 1, 7'h01, 7, 1'b1};
        tbl[2] = '{32'd0, 36'd1,            0, 36'd0,            1'b0, 0, 0, 7'h00, 1, 1'b0};
        tbl[3] = '{32'd5, 36'd1,            2, 36'd0,            1'b0, 5, 5, 7'h55, 8, 1'b1};
        tbl[4] = '{32'd1, 36'h8_0000_0000,  1, 36'h8_0000_0000,  1'b0, 1, 1, 7'h01, 4, 1'b1};
        tbl[5] = '{32'd2, 36'd0,            1, 36'd2,            1'b0, 2, 1, 7'h01, 5, 1'b1};

        // Reset held for two edges with start asserted.
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; num_vectors = 32'd3; seed = 36'd1;
        tick(); tick();
        check("rst_dut_in",    64'(dut_in),    64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_done",      64'(done),      64'd0);
        check("rst_inj_en",    64'(inj_en),    64'd0);
        check("rst_vec_count", 64'(vec_count), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_err_bits",  64'(err_bits),  64'd0);
        rst_n = 1'b1; start = 1'b0;
        tick(); tick();
        check("idle_no_run_busy", 64'(busy),   64'd0);
        check("idle_dut_in",      64'(dut_in), 64'd0);

        // dut_in stream 1,2,4 while running, then held in DRAIN.
        fault_mode = 0; num_vectors = 32'd3; seed = 36'd1; start = 1'b1;
        tick(); start = 1'b0;
        check("seq_dut_in_0", 64'(dut_in), 64'd1);
        check("seq_busy",     64'(busy),   64'd1);
        check("seq_inj_en",   64'(inj_en), 64'd1);
        tick(); check("seq_dut_in_1", 64'(dut_in), 64'd2);
        tick(); check("seq_dut_in_2", 64'(dut_in), 64'd4);
        tick(); check("seq_dut_in_3", 64'(dut_in), 64'd8);
        tick(); check("seq_drain_hold", 64'(dut_in), 64'd8);
        check("seq_drain_busy", 64'(busy), 64'd1);
        wait_done(edges);
        check("seq_done", 64'(done), 64'd1);

        // Feedback tap at bit 24 feeds bit 0.
        num_vectors = 32'd2; seed = 36'h0_0100_0000; start = 1'b1;
        tick(); start = 1'b0;
        check("lfsr_seed",  64'(dut_in), 64'h0_0100_0000);
        tick(); check("lfsr_step1", 64'(dut_in), 64'h0_0200_0001);
        tick(); check("lfsr_step2", 64'(dut_in), 64'h0_0400_0002);
        wait_done(edges);

        // Whole-campaign table.
        for (int i = 0; i < NCASE; i++) begin
            fault_mode  = tbl[i].mode;
            bad_vec     = tbl[i].bad;
            num_vectors = tbl[i].n;
            seed        = tbl[i].seed;
            abort       = tbl[i].abort_in;
            start       = 1'b1;
            tick();
            start = 1'b0; abort = 1'b0;
            inj_seen = inj_en;
            edges = 0;
            while (!done && edges < 300) begin
                tick();
                edges++;
                inj_seen = inj_seen | inj_en;
            end
            check($sformatf("case%0d_done_edges", i), 64'(edges),     64'(tbl[i].exp_edges));
            check($sformatf("case%0d_vec_count", i),  64'(vec_count), 64'(tbl[i].exp_vec));
            check($sformatf("case%0d_err_count", i),  64'(err_count), 64'(tbl[i].exp_err));
            check($sformatf("case%0d_err_bits", i),   64'(err_bits),  64'(tbl[i].exp_bits));
            check($sformatf("case%0d_inj_seen", i),   64'(inj_seen),  64'(tbl[i].exp_inj));
            check($sformatf("case%0d_busy_low", i),   64'(busy),      64'd0);
        end

        // Abort after five issued vectors; a start while busy must be ignored.
        fault_mode = 0; num_vectors = 32'd100; seed = 36'd1; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        start = 1'b1; num_vectors = 32'd7;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        abort = 1'b1;
        tick(); abort = 1'b0;
        check("abort_busy",   64'(busy),   64'd1);
        check("abort_dut_in", 64'(dut_in), 64'd32);
        wait_done(edges);
        check("abort_drain_edges", 64'(edges),     64'd2);
        check("abort_vec_count",   64'(vec_count), 64'd5);
        check("abort_err_count",   64'(err_count), 64'd0);
        tick(); tick(); tick();
        check("hold_vec_count", 64'(vec_count), 64'd5);
        check("hold_done",      64'(done),      64'd1);

        // Error counter saturation with a zero seed.
        fault_mode = 2; num_vectors = 32'd3; seed = 36'd0; start = 1'b1;
        tick(); start = 1'b0;
        check("sat_seed_zero", 64'(dut_in), 64'd1);
        force dut.err_count = 32'hFFFF_FFFE;
        #1;
        release dut.err_count;
        wait_done(edges);
        check("sat_err_count", 64'(err_count), 64'h0000_0000_FFFF_FFFF);
        check("sat_vec_count", 64'(vec_count), 64'd3);
        check("sat_err_bits",  64'(err_bits),  64'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
